// File: rtl/target_motion_ctrl_if.sv
// Request channel from the target sequencer to the sprite drawer.
// Fields are held with draw_req until the drawer returns a one-cycle draw_ack.
interface target_motion_ctrl_if #(
    parameter int IDX_W = 1,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) ();
    logic             draw_req;
    logic             draw_erase;
    logic [IDX_W-1:0] draw_idx;
    logic [X_W-1:0]   draw_x;
    logic [Y_W-1:0]   draw_y;
    logic             draw_ack;

    modport master (output draw_req, draw_erase, draw_idx, draw_x, draw_y, input draw_ack);
    modport slave  (input draw_req, draw_erase, draw_idx, draw_x, draw_y, output draw_ack);
endinterface

// File: rtl/target_motion_ctrl.sv
// Multi-target movement sequencer: per tick rise, erase/move/redraw each live target in index order.
// Latency: sweep starts the cycle after the tick rise; MOVE is one cycle between the erase and draw handshakes.
// Backpressure: each request holds until draw_ack; tick rises arriving mid-sweep are dropped.
module target_motion_ctrl #(
    parameter int NUM_TGT   = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int X_MAX     = 152,
    parameter int Y_MAX     = 100,
    parameter int STEP      = 1,
    parameter int DIR_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic                   spawn,
    input  logic [X_W-1:0]         spawn_x,
    input  logic [Y_W-1:0]         spawn_y,
    input  logic [2*NUM_TGT-1:0]   rand_bits,
    input  logic [NUM_TGT-1:0]     shot,
    input  logic [NUM_TGT-1:0]     escape,
    target_motion_ctrl_if.master   draw,
    output logic [2*NUM_TGT-1:0]   tgt_mode,
    output logic                   sweep_busy,
    output logic                   all_gone
);
    localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int DC_W  = (DIR_TICKS > 1) ? $clog2(DIR_TICKS) : 1;

    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DIR_TICKS - 1);
    localparam logic [IDX_W:0]   IDX_END  = (IDX_W+1)'(NUM_TGT);
    localparam logic [IDX_W:0]   IDX_ONE  = (IDX_W+1)'(1);
    localparam logic [X_W-1:0]   STEP_X   = X_W'(STEP);
    localparam logic [Y_W-1:0]   STEP_Y   = Y_W'(STEP);
    localparam logic [X_W-1:0]   XMAX_X   = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   YMAX_Y   = Y_W'(Y_MAX);
    localparam logic [X_W:0]     STEP_XE  = (X_W+1)'(STEP);
    localparam logic [Y_W:0]     STEP_YE  = (Y_W+1)'(STEP);
    localparam logic [X_W:0]     XMAX_XE  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]     YMAX_YE  = (Y_W+1)'(Y_MAX);

    localparam logic [1:0] M_GONE  = 2'b00;
    localparam logic [1:0] M_ALIVE = 2'b01;
    localparam logic [1:0] M_FALL  = 2'b10;
    localparam logic [1:0] M_FLEE  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ERASE, S_MOVE, S_DRAW} state_t;

    state_t           state;
    logic [X_W-1:0]   pos_x [NUM_TGT];
    logic [Y_W-1:0]   pos_y [NUM_TGT];
    logic             dir_x [NUM_TGT];
    logic             dir_y [NUM_TGT];
    logic [1:0]       mode  [NUM_TGT];
    logic [DC_W-1:0]  dir_cnt;
    logic [IDX_W:0]   scan_idx;
    logic             tick_q;
    logic             spawn_pend;

    logic             tick_rise;
    logic [IDX_W-1:0] cur;
    logic [X_W-1:0]   sx_cl, nx;
    logic [Y_W-1:0]   sy_cl, ny;
    logic [X_W:0]     xe;
    logic [Y_W:0]     ye;
    logic             ndx, ndy;
    logic [1:0]       nmode;

    assign tick_rise = tick & ~tick_q;
    assign cur       = scan_idx[IDX_W-1:0];
    assign sx_cl     = (spawn_x > XMAX_X) ? XMAX_X : spawn_x;
    assign sy_cl     = (spawn_y > YMAX_Y) ? YMAX_Y : spawn_y;

    // Next position/direction/mode of the target under the scan pointer; bounds clamp, never wrap.
    always_comb begin
        nx    = pos_x[cur];
        ny    = pos_y[cur];
        ndx   = dir_x[cur];
        ndy   = dir_y[cur];
        nmode = mode[cur];
        xe    = {1'b0, pos_x[cur]};
        ye    = {1'b0, pos_y[cur]};
        case (mode[cur])
            M_ALIVE: begin
                if (dir_x[cur]) begin
                    if (xe + STEP_XE > XMAX_XE) begin nx = XMAX_X; ndx = 1'b0; end
                    else                              nx = pos_x[cur] + STEP_X;
                end else begin
                    if (xe < STEP_XE) begin nx = '0; ndx = 1'b1; end
                    else                  nx = pos_x[cur] - STEP_X;
                end
                if (dir_y[cur]) begin
                    if (ye + STEP_YE > YMAX_YE) begin ny = YMAX_Y; ndy = 1'b0; end
                    else                              ny = pos_y[cur] + STEP_Y;
                end else begin
                    if (ye < STEP_YE) begin ny = '0; ndy = 1'b1; end
                    else                  ny = pos_y[cur] - STEP_Y;
                end
            end
            M_FALL: begin
                if (ye + STEP_YE >= YMAX_YE) begin ny = YMAX_Y; nmode = M_GONE; end
                else                               ny = pos_y[cur] + STEP_Y;
            end
            M_FLEE: begin
                if (ye <= STEP_YE) begin ny = '0; nmode = M_GONE; end
                else                     ny = pos_y[cur] - STEP_Y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            dir_cnt         <= '0;
            scan_idx        <= '0;
            tick_q          <= 1'b0;
            spawn_pend      <= 1'b0;
            sweep_busy      <= 1'b0;
            draw.draw_req   <= 1'b0;
            draw.draw_erase <= 1'b0;
            draw.draw_idx   <= '0;
            draw.draw_x     <= '0;
            draw.draw_y     <= '0;
            for (int i = 0; i < NUM_TGT; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir_x[i] <= 1'b1;
                dir_y[i] <= 1'b0;
                mode[i]  <= M_GONE;
            end
        end else begin
            tick_q <= tick;
            for (int i = 0; i < NUM_TGT; i++) begin
                if (mode[i] == M_ALIVE) begin
                    if (shot[i])        mode[i] <= M_FALL;
                    else if (escape[i]) mode[i] <= M_FLEE;
                end
            end
            case (state)
                S_IDLE: begin
                    if (spawn) begin
                        // A tick rise coincident with spawn is remembered and starts the sweep next cycle.
                        spawn_pend <= tick_rise;
                        dir_cnt    <= '0;
                        for (int i = 0; i < NUM_TGT; i++) begin
                            pos_x[i] <= sx_cl;
                            pos_y[i] <= sy_cl;
                            mode[i]  <= M_ALIVE;
                        end
                    end else if (tick_rise || spawn_pend) begin
                        spawn_pend <= 1'b0;
                        sweep_busy <= 1'b1;
                        scan_idx   <= '0;
                        state      <= S_SCAN;
                        dir_cnt    <= (dir_cnt == DC_LAST) ? '0 : dir_cnt + DC_W'(1);
                        if (dir_cnt == '0) begin
                            for (int i = 0; i < NUM_TGT; i++) begin
                                if (mode[i] == M_ALIVE) begin
                                    dir_x[i] <= rand_bits[2*i];
                                    dir_y[i] <= rand_bits[2*i+1];
                                end
                            end
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_idx == IDX_END) begin
                        sweep_busy <= 1'b0;
                        state      <= S_IDLE;
                    end else if (mode[cur] != M_GONE) begin
                        draw.draw_req   <= 1'b1;
                        draw.draw_erase <= 1'b1;
                        draw.draw_idx   <= cur;
                        draw.draw_x     <= pos_x[cur];
                        draw.draw_y     <= pos_y[cur];
                        state           <= S_ERASE;
                    end else begin
                        scan_idx <= scan_idx + IDX_ONE;
                    end
                end
                S_ERASE: begin
                    if (draw.draw_ack) begin
                        draw.draw_req <= 1'b0;
                        state         <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    pos_x[cur] <= nx;
                    pos_y[cur] <= ny;
                    dir_x[cur] <= ndx;
                    dir_y[cur] <= ndy;
                    // ALIVE never changes mode here, so a same-cycle shot/escape above is kept.
                    if (mode[cur] != M_ALIVE) mode[cur] <= nmode;
                    if (nmode == M_GONE) begin
                        scan_idx <= scan_idx + IDX_ONE;
                        state    <= S_SCAN;
                    end else begin
                        draw.draw_req   <= 1'b1;
                        draw.draw_erase <= 1'b0;
                        draw.draw_x     <= nx;
                        draw.draw_y     <= ny;
                        state           <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (draw.draw_ack) begin
                        draw.draw_req <= 1'b0;
                        scan_idx      <= scan_idx + IDX_ONE;
                        state         <= S_SCAN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tgt_mode = '0;
        for (int i = 0; i < NUM_TGT; i++) tgt_mode[2*i +: 2] = mode[i];
    end

    assign all_gone = (tgt_mode == '0);

endmodule
